// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data RAM controller: FSM states, strobe width, byte parity.
package data_ram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

   // Even parity: the stored bit makes the total count of ones in byte+bit even.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between the load/store unit (master) and data_ram_ctrl (slave).
interface data_ram_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                        req_valid;
   logic                        req_ready;
   logic                        req_write;
   logic [ADDR_WIDTH-1:0]       req_addr;
   logic [DATA_WIDTH-1:0]       req_wdata;
   logic [DATA_WIDTH/8-1:0]     req_wstrb;
   logic                        clear_req;
   logic                        parity_inject;
   logic                        rsp_valid;
   logic [DATA_WIDTH-1:0]       rsp_rdata;
   logic                        rsp_error;
   logic                        rsp_parity_err;
   logic                        init_busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, clear_req, parity_inject,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_parity_err, init_busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, clear_req, parity_inject,
      output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_parity_err, init_busy
   );
endinterface

// File: rtl/data_ram_array.sv
// Storage only: byte-enabled synchronous write, registered read that holds between reads.
// Per-byte parity storage exists when DATA_RAM_PARITY_EN is defined.
module data_ram_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 351,
   parameter int IDX_W      = 9,
   parameter int STRB_W     = 4
) (
   input  logic                  i_clock,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [IDX_W-1:0]      i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [STRB_W-1:0]     i_wstrb,
`ifdef DATA_RAM_PARITY_EN
   input  logic [STRB_W-1:0]     i_wpar,
   output logic [STRB_W-1:0]     o_rpar,
`endif
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;
`ifdef DATA_RAM_PARITY_EN
   logic [STRB_W-1:0]     r_par [DEPTH];
   logic [STRB_W-1:0]     r_rpar;
`endif

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (i_wstrb[i]) begin
               r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
`ifdef DATA_RAM_PARITY_EN
               r_par[i_addr][i] <= i_wpar[i];
`endif
            end
         end
      end
      // The read register only loads on a read so a response holds until the next one.
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
`ifdef DATA_RAM_PARITY_EN
         r_rpar  <= r_par[i_addr];
`endif
      end
   end

   assign o_rdata = r_rdata;
`ifdef DATA_RAM_PARITY_EN
   assign o_rpar  = r_rpar;
`endif

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: clear sequencer FSM, range check and 1-cycle response path.
// Optional per-byte parity checking is enabled by defining DATA_RAM_PARITY_EN.
module data_ram_ctrl
   import data_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 351,
   parameter int INIT_CLEAR = 1
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   data_ram_ctrl_if.slave bus
);

   localparam int                  STRB_W   = strb_width(DATA_WIDTH);
   localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

   state_t                r_state, w_state_nxt;
   logic [IDX_W-1:0]      r_clr_addr, w_clr_addr_nxt;
   logic                  w_accept, w_in_range, w_we, w_re;
   logic [IDX_W-1:0]      w_addr;
   logic [DATA_WIDTH-1:0] w_wdata, w_rdata;
   logic [STRB_W-1:0]     w_wstrb;
   logic                  r_rsp_valid, r_rsp_error, r_rd_ok;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state    <= (INIT_CLEAR != 0) ? INIT : RUN;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      case (r_state)
         INIT: begin
            if (r_clr_addr == LAST_IDX) begin
               w_state_nxt    = RUN;
               w_clr_addr_nxt = '0;
            end else begin
               w_clr_addr_nxt = r_clr_addr + IDX_W'(1);
            end
         end
         RUN: begin
            if (bus.clear_req) begin
               w_state_nxt    = INIT;
               w_clr_addr_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   // Ready drops in the clear_req cycle so no request slips in as the clear starts.
   assign bus.req_ready = (r_state == RUN) && !bus.clear_req;
   assign bus.init_busy = (r_state == INIT);

   assign w_accept   = bus.req_valid && bus.req_ready;
   assign w_in_range = {1'b0, bus.req_addr} < DEPTH_A;
   assign w_we       = (r_state == INIT) || (w_accept && bus.req_write && w_in_range);
   assign w_re       = w_accept && !bus.req_write && w_in_range;
   assign w_addr     = (r_state == INIT) ? r_clr_addr : bus.req_addr[IDX_W-1:0];
   assign w_wdata    = (r_state == INIT) ? '0 : bus.req_wdata;
   assign w_wstrb    = (r_state == INIT) ? '1 : bus.req_wstrb;

`ifdef DATA_RAM_PARITY_EN
   logic [STRB_W-1:0] w_wpar, w_rpar, w_rpar_calc;

   always_comb begin
      w_wpar      = '0;
      w_rpar_calc = '0;
      for (int i = 0; i < STRB_W; i++) begin
         if (r_state == RUN) begin
            w_wpar[i] = byte_parity(bus.req_wdata[8*i +: 8]) ^ bus.parity_inject;
         end
         w_rpar_calc[i] = byte_parity(w_rdata[8*i +: 8]);
      end
   end

   assign bus.rsp_parity_err = r_rd_ok && (w_rpar != w_rpar_calc);
`else
   logic w_unused_inject;
   assign w_unused_inject    = bus.parity_inject;
   assign bus.rsp_parity_err = 1'b0;
`endif

   data_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W),
      .STRB_W     (STRB_W)
   ) u_array (
      .i_clock (i_clock),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .i_wstrb (w_wstrb),
`ifdef DATA_RAM_PARITY_EN
      .i_wpar  (w_wpar),
      .o_rpar  (w_rpar),
`endif
      .o_rdata (w_rdata)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_error <= 1'b0;
         r_rd_ok     <= 1'b0;
      end else begin
         r_rsp_valid <= w_accept;
         if (w_accept) begin
            r_rsp_error <= !w_in_range;
            r_rd_ok     <= !bus.req_write && w_in_range;
         end
      end
   end

   // Write and out-of-range responses mask the held array read register to zero.
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_error = r_rsp_error;
   assign bus.rsp_rdata = r_rd_ok ? w_rdata : '0;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: expected responses queued at acceptance, compared on rsp_valid.
module tb_data_ram_ctrl;

   localparam int DEPTH = 351;

   logic clk;
   logic rst_n;

   data_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

   data_ram_ctrl #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .DEPTH      (DEPTH),
      .INIT_CLEAR (1)
   ) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        perr;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] mdl [DEPTH];
   logic [3:0]  bad [DEPTH];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_req    = 0;
   int          n_rsp    = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         exp_t e;
         n_rsp++;
         if (expq.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
         end else begin
            e = expq.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_error", bus.rsp_error, e.err);
            chk("rsp_parity_err", bus.rsp_parity_err, e.perr);
         end
      end
   end

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      bus.clear_req = 1'b0;
      bus.parity_inject = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_req(input logic wr, input int addr, input logic [31:0] d,
                         input logic [3:0] s, input logic inj);
      exp_t e;
      int   w;
      bus.req_valid     = 1'b1;
      bus.req_write     = wr;
      bus.req_addr      = 10'(addr);
      bus.req_wdata     = d;
      bus.req_wstrb     = s;
      bus.parity_inject = inj;
      w = 0;
      while (!bus.req_ready && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w == 50) chk("req_ready_timeout", 0, 1);
      e.err   = (addr >= DEPTH);
      e.rdata = '0;
      e.perr  = 1'b0;
      if (addr < DEPTH) begin
         if (wr) begin
            for (int i = 0; i < 4; i++) begin
               if (s[i]) begin
                  mdl[addr][8*i +: 8] = d[8*i +: 8];
                  bad[addr][i] = inj;
               end
            end
         end else begin
            e.rdata = mdl[addr];
`ifdef DATA_RAM_PARITY_EN
            e.perr = |bad[addr];
`endif
         end
      end
      expq.push_back(e);
      n_req++;
      @(posedge clk);
      #1;
   endtask

   task automatic count_busy(output int n, output logic ready_seen);
      n = 0;
      ready_seen = 1'b0;
      while (bus.init_busy && n < 1000) begin
         if (bus.req_ready) ready_seen = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < DEPTH; a++) begin
         mdl[a] = '0;
         bad[a] = '0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          nb;
      logic        rdy;
      logic [31:0] d;
      rst_n             = 1'b0;
      bus.req_valid     = 1'b0;
      bus.req_write     = 1'b0;
      bus.req_addr      = '0;
      bus.req_wdata     = '0;
      bus.req_wstrb     = '0;
      bus.clear_req     = 1'b0;
      bus.parity_inject = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_rsp_error", bus.rsp_error, 0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 0);
      chk("reset_rsp_parity_err", bus.rsp_parity_err, 0);
      chk("reset_init_busy", bus.init_busy, 1);
      chk("reset_req_ready", bus.req_ready, 0);
      rst_n = 1'b1;

      count_busy(nb, rdy);
      chk("init_cycles", nb, DEPTH);
      chk("init_ready_low", rdy, 0);
      chk("run_ready", bus.req_ready, 1);
      do_req(0, 200, 0, 0, 0);
      idle(1);

      do_req(1, 5, 32'hAABBCCDD, 4'hF, 0);
      do_req(1, 5, 32'h11223344, 4'b0101, 0);
      do_req(0, 5, 0, 0, 0);
      idle(3);
      chk("byte_merge_hold", bus.rsp_rdata, 32'hAA22CC44);
      chk("rsp_valid_pulse", bus.rsp_valid, 0);

      do_req(1, 7, 32'h5A5AF00D, 4'hF, 0);
      do_req(0, 7, 0, 0, 0);
      idle(2);
      chk("rsp_count_b2b", n_rsp, n_req);

      do_req(0, 400, 0, 0, 0);
      do_req(1, 400, 32'hFFFFFFFF, 4'hF, 0);
      do_req(1, 656, 32'hFFFFFFFF, 4'hF, 0);
      idle(1);
      for (int a = 0; a < DEPTH; a++) do_req(0, a, 0, 0, 0);
      idle(2);

      for (int a = 0; a < 10; a++) begin
         d = $urandom;
         do_req(1, a, d, 4'(a + 6), 0);
      end
      for (int a = 0; a < 10; a++) do_req(0, a, 0, 0, 0);
      idle(2);

      bus.clear_req = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 10'd0;
      bus.req_wdata = 32'hDEADBEEF;
      bus.req_wstrb = 4'hF;
      #1;
      chk("ready_low_on_clear", bus.req_ready, 0);
      @(posedge clk);
      #1;
      bus.clear_req = 1'b0;
      bus.req_valid = 1'b0;
      model_clear();
      count_busy(nb, rdy);
      chk("clear_cycles", nb, DEPTH);
      chk("clear_ready_low", rdy, 0);
      for (int a = 0; a < 10; a++) do_req(0, a, 0, 0, 0);
      idle(2);

      do_req(1, 300, 32'h12345678, 4'hF, 0);
      idle(1);
      bus.clear_req = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_req = 1'b0;
      repeat (100) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      count_busy(nb, rdy);
      chk("restart_clear_cycles", nb, DEPTH);
      do_req(0, 300, 0, 0, 0);
      do_req(0, 350, 0, 0, 0);
      idle(2);

      do_req(1, 3, 32'hCAFEF00D, 4'hF, 0);
      do_req(1, 3, 32'h0000A500, 4'b0010, 1);
      do_req(0, 3, 0, 0, 0);
      do_req(1, 3, 32'h00003C00, 4'b0010, 0);
      do_req(0, 3, 0, 0, 0);
      idle(3);

      chk("rsp_count_total", n_rsp, n_req);
      chk("queue_empty", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
